// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - captures an NxN accumulator matrix, requantizes to S5.10, drains one row per beat
module systolic_result_drain #(
  parameter int ARRAY_SIZE  = 4,
  parameter int ACCUM_WIDTH = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_SHIFT  = 6,
  localparam int IDX_WIDTH  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      acc_valid,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] acc_flat,
  output logic                                      acc_ready,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]          out_row,
  output logic [IDX_WIDTH-1:0]                      out_row_idx,
  output logic                                      out_last,
  output logic                                      out_row_sat,
  output logic                                      busy,
  output logic [15:0]                               sat_count
);

  localparam int AW = ACCUM_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int N  = ARRAY_SIZE;
  localparam int RW = AW * N;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N - 1);
  localparam logic signed [AW:0] RND  = {{AW{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [AW:0] QMAX = {{(AW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW:0] QMIN = {{(AW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state;
  logic [RW*N-1:0]          cap_buf;
  logic [IDX_WIDTH-1:0]     ptr;
  logic [N-1:0]             row_sat_vec;

  logic [IDX_WIDTH-1:0]     nxt_ptr;
  logic [RW-1:0]            src_row;
  logic [DW*N-1:0]          conv_row;
  logic [N-1:0]             conv_sat;
  logic [AW-1:0]            elem;
  logic signed [AW:0]       t_val;
  logic signed [AW:0]       q_val;
  logic [15:0]              row_sat_cnt;
  logic [16:0]              sat_sum;
  logic [15:0]              sat_next;

  assign acc_ready   = (state == IDLE);
  assign busy        = (state == DRAIN);
  assign out_row_idx = ptr;
  assign out_last    = out_valid && (ptr == LAST);

  // In IDLE the converter looks at the live input (row 0 is registered on the
  // capture edge); in DRAIN it looks ahead at the next buffered row.
  always_comb begin
    nxt_ptr  = (ptr == LAST) ? '0 : ptr + 1'b1;
    src_row  = acc_flat[RW-1:0];
    conv_row = '0;
    conv_sat = '0;
    elem     = '0;
    t_val    = '0;
    q_val    = '0;
    if (state == DRAIN) begin
      for (int r = 0; r < N; r++) begin
        if (IDX_WIDTH'(r) == nxt_ptr) src_row = cap_buf[r*RW +: RW];
      end
    end
    for (int c = 0; c < N; c++) begin
      elem  = src_row[c*AW +: AW];
      t_val = {elem[AW-1], elem} + RND;
      q_val = t_val >>> FRAC_SHIFT;
      if (q_val > QMAX) begin
        conv_row[c*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
        conv_sat[c]          = 1'b1;
      end else if (q_val < QMIN) begin
        conv_row[c*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
        conv_sat[c]          = 1'b1;
      end else begin
        conv_row[c*DW +: DW] = q_val[DW-1:0];
      end
    end
  end

  always_comb begin
    row_sat_cnt = '0;
    for (int c = 0; c < N; c++) row_sat_cnt = row_sat_cnt + 16'(row_sat_vec[c]);
    sat_sum  = {1'b0, sat_count} + {1'b0, row_sat_cnt};
    sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_sat <= 1'b0;
      row_sat_vec <= '0;
      sat_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_valid) begin
            cap_buf     <= acc_flat;
            ptr         <= '0;
            out_row     <= conv_row;
            row_sat_vec <= conv_sat;
            out_row_sat <= |conv_sat;
            out_valid   <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            sat_count <= sat_next;
            if (ptr == LAST) begin
              out_valid <= 1'b0;
              ptr       <= '0;
              state     <= IDLE;
            end else begin
              ptr         <= nxt_ptr;
              out_row     <= conv_row;
              row_sat_vec <= conv_sat;
              out_row_sat <= |conv_sat;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - directed bench for systolic_result_drain with N=2
module tb_systolic_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         acc_valid;
  logic [127:0] acc_flat;
  logic         acc_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_row;
  logic [0:0]   out_row_idx;
  logic         out_last;
  logic         out_row_sat;
  logic         busy;
  logic [15:0]  sat_count;

  int checks = 0;
  int errors = 0;

  systolic_result_drain #(
    .ARRAY_SIZE(2), .ACCUM_WIDTH(32), .DATA_WIDTH(16), .FRAC_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_flat(acc_flat), .acc_ready(acc_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .out_row_sat(out_row_sat),
    .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mat(input logic [31:0] a00, input logic [31:0] a01,
                                       input logic [31:0] a10, input logic [31:0] a11);
    return {a11, a10, a01, a00};
  endfunction

  task automatic chk_beat(input string tag, input logic [31:0] row, input logic idx,
                          input logic last, input logic sat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_row"}, out_row, row);
    chk({tag, "_idx"}, 32'(out_row_idx), 32'(idx));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_sat"}, 32'(out_row_sat), 32'(sat));
  endtask

  initial begin
    rst = 1'b1; acc_valid = 1'b0; acc_flat = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_row", out_row, 32'd0);
    chk("rst_idx", 32'(out_row_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_row_sat", 32'(out_row_sat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_acc_ready", 32'(acc_ready), 32'd1);

    // identity matrix, consumer always ready
    acc_flat = mat(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
    acc_valid = 1'b1; out_ready = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk_beat("id_b0", 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    chk("id_busy", 32'(busy), 32'd1);
    chk("id_acc_ready", 32'(acc_ready), 32'd0);
    tick();
    chk_beat("id_b1", 32'h0400_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("id_end_valid", 32'(out_valid), 32'd0);
    chk("id_end_ready", 32'(acc_ready), 32'd1);
    chk("id_end_busy", 32'(busy), 32'd0);

    // rounding edge cases
    acc_flat = mat(32'h0000_0020, 32'h0000_001F, 32'hFFFF_FFE0, 32'hFFFF_FFDF);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk_beat("rnd_b0", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk_beat("rnd_b1", 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rnd_sat_count", 32'(sat_count), 32'd0);

    // saturation both directions, including max positive accumulator
    acc_flat = mat(32'h0020_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk_beat("sat_b0", 32'h8000_7FFF, 1'b0, 1'b0, 1'b1);
    chk("sat_cnt0", 32'(sat_count), 32'd0);
    tick();
    chk_beat("sat_b1", 32'h0000_7FFF, 1'b1, 1'b1, 1'b1);
    chk("sat_cnt1", 32'(sat_count), 32'd2);
    tick();
    chk("sat_cnt2", 32'(sat_count), 32'd3);
    chk("sat_end_valid", 32'(out_valid), 32'd0);

    // backpressure with ignored capture attempts during DRAIN
    out_ready = 1'b0;
    acc_flat = mat(32'h0001_0000, 32'h0000_0040, 32'h0000_0080, 32'h0);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk_beat("bp_b0", 32'h0001_0400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      acc_valid = 1'b1;
      acc_flat = mat(32'h0123_4567, 32'h0765_4321, 32'h0000_1000, 32'h0000_2000);
      tick();
      chk_beat("bp_hold", 32'h0001_0400, 1'b0, 1'b0, 1'b0);
      chk("bp_acc_ready", 32'(acc_ready), 32'd0);
    end
    acc_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_beat("bp_b1", 32'h0000_0002, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp_no_extra", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(sat_count), 32'd3);

    // reset after beat 0 is accepted
    acc_flat = mat(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    tick();
    chk_beat("mr_b1", 32'h0400_0000, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cnt", 32'(sat_count), 32'd0);
    chk("mr_acc_ready", 32'(acc_ready), 32'd1);
    tick(); tick();
    chk("mr_no_beat", 32'(out_valid), 32'd0);
    acc_flat = mat(32'h0000_0020, 32'h0000_001F, 32'hFFFF_FFE0, 32'hFFFF_FFDF);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    chk_beat("mr_f_b0", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk_beat("mr_f_b1", 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mr_f_end", 32'(out_valid), 32'd0);

    // back-to-back frames with acc_valid held high and data changing after capture
    acc_valid = 1'b1;
    acc_flat = mat(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
    tick();
    acc_flat = mat(32'h0000_0020, 32'h0000_001F, 32'hFFFF_FFE0, 32'hFFFF_FFDF);
    chk_beat("bb_a0", 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    tick();
    chk_beat("bb_a1", 32'h0400_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bb_gap_valid", 32'(out_valid), 32'd0);
    chk("bb_gap_ready", 32'(acc_ready), 32'd1);
    tick();
    acc_flat = mat(32'h0020_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
    chk_beat("bb_b0", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk_beat("bb_b1", 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
    acc_valid = 1'b0;
    tick();
    chk("bb_end_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bb_idle", 32'(out_valid), 32'd0);
    chk("bb_cnt", 32'(sat_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
